pwm_decoder: RTL and testbench



---
 rtl/pwm_decoder.sv | 62 ++++++
 tb/tb_pwm_decoder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures per-period high time and period of an async PWM input, flags loss of signal
module pwm_decoder #(
  parameter int CNT_W   = 7,
  parameter int TIMEOUT = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             no_signal,
  output logic             level
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  state_t r_state, w_state_nxt;
  logic r_ff1, r_s, r_s_prev, r_valid, r_no_signal;
  logic [CNT_W-1:0] r_hc, r_pc, r_high_cnt, r_period_cnt, w_hc_nxt, w_pc_nxt;
  logic w_rise, w_fall, w_tmo, w_report;
  assign w_rise     = r_s & ~r_s_prev;
  assign w_fall     = ~r_s & r_s_prev;
  assign w_tmo      = (r_state != IDLE) && (r_pc == TMO) && !w_rise;
  assign w_report   = (r_state == LOW) && w_rise;
  assign high_cnt   = r_high_cnt;
  assign period_cnt = r_period_cnt;
  assign valid      = r_valid;
  assign no_signal  = r_no_signal;
  assign level      = r_s;
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // a rise cannot occur while in HIGH, so rise always (re)starts a measurement
  always_comb begin
    w_state_nxt = w_rise ? HIGH : w_tmo ? IDLE : (w_fall && r_state == HIGH) ? LOW : r_state;
    w_hc_nxt    = w_rise ? ONE : (r_state == HIGH && r_s) ? r_hc + ONE : r_hc;
    w_pc_nxt    = w_rise ? ONE : (r_state != IDLE && !w_tmo) ? r_pc + ONE : r_pc;
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_ff1        <= 1'b0;
      r_s          <= 1'b0;
      r_s_prev     <= 1'b0;
      r_hc         <= '0;
      r_pc         <= '0;
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
      r_valid      <= 1'b0;
      r_no_signal  <= 1'b1;
    end else begin
      r_ff1        <= pwm_in;
      r_s          <= r_ff1;
      r_s_prev     <= r_s;
      r_hc         <= w_hc_nxt;
      r_pc         <= w_pc_nxt;
      r_valid      <= w_report;
      r_high_cnt   <= w_report ? r_hc : r_high_cnt;
      r_period_cnt <= w_report ? r_pc : r_period_cnt;
      r_no_signal  <= w_report ? 1'b0 : w_tmo ? 1'b1 : r_no_signal;
    end
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed table-driven check of pwm_decoder measurement, timeout and reset behaviour
module tb_pwm_decoder;
  logic clk = 1'b0, reset = 1'b1, pwm_in = 1'b0;
  logic [6:0] high_cnt, period_cnt;
  logic valid, no_signal, level;
  pwm_decoder #(.CNT_W(7), .TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .high_cnt(high_cnt), .period_cnt(period_cnt),
    .valid(valid), .no_signal(no_signal), .level(level)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int vh[$], vp[$], vt[$], rq[$];
  always @(negedge clk)
    if (valid) begin
      vh.push_back(int'(high_cnt));
      vp.push_back(int'(period_cnt));
      vt.push_back(cyc);
    end
  int checks = 0, errors = 0;
  typedef struct {int h; int p; int n; int eh; int ep;} vec_t;
  vec_t tbl[7];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (v && !pwm_in) rq.push_back(cyc + 1);
      pwm_in = v;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive_period(input int h, input int p);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask
  task automatic do_reset(input int n);
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_high_cnt"}, int'(high_cnt), 0);
    chk({tag, "_period_cnt"}, int'(period_cnt), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_no_signal"}, int'(no_signal), 1);
    chk({tag, "_level"}, int'(level), 0);
  endtask
  task automatic chk_run(input string tag, input int vb, input int rb, input int n, input int h, input int p);
    chk({tag, "_count"}, vh.size() - vb, n);
    for (int i = 0; i < n && vb + i < vh.size(); i++) begin
      chk({tag, "_high"}, vh[vb + i], h);
      chk({tag, "_period"}, vp[vb + i], p);
      if (i > 0) chk({tag, "_spacing"}, vt[vb + i] - vt[vb + i - 1], p);
    end
    if (vh.size() > vb && rq.size() > rb + 1) chk({tag, "_first_valid_time"}, vt[vb], rq[rb + 1] + 2);
  endtask
  initial begin
    int vb, rb, r;
    tbl[0] = '{20, 50, 10, 20, 50};
    tbl[1] = '{1, 50, 4, 1, 50};
    tbl[2] = '{49, 50, 4, 49, 50};
    tbl[3] = '{30, 100, 2, 30, 100};
    tbl[4] = '{1, 2, 5, 1, 2};
    tbl[5] = '{5, 7, 4, 5, 7};
    tbl[6] = '{99, 100, 2, 99, 100};
    do_reset(3);
    chk_reset_state("reset");
    for (int t = 0; t < 7; t++) begin
      do_reset(1);
      vb = vh.size();
      rb = rq.size();
      for (int k = 0; k < tbl[t].n; k++) drive_period(tbl[t].h, tbl[t].p);
      drive(1'b1, 1);
      drive(1'b0, 4);
      chk_run($sformatf("vec%0d", t), vb, rb, tbl[t].n, tbl[t].eh, tbl[t].ep);
      chk($sformatf("vec%0d_no_signal", t), int'(no_signal), 0);
    end
    do_reset(1);
    vb = vh.size();
    drive(1'b0, 300);
    chk("stuck_low_count", vh.size() - vb, 0);
    chk_reset_state("stuck_low");
    do_reset(1);
    vb = vh.size();
    for (int k = 0; k < 3; k++) drive_period(20, 50);
    drive(1'b1, 1);
    r = rq[rq.size() - 1];
    while (cyc < r + 101) drive(1'b1, 1);
    chk("stuck_high_before_timeout", int'(no_signal), 0);
    drive(1'b1, 1);
    chk("stuck_high_timeout", int'(no_signal), 1);
    chk("stuck_high_level", int'(level), 1);
    chk("stuck_high_held_high", int'(high_cnt), 20);
    chk("stuck_high_held_period", int'(period_cnt), 50);
    drive(1'b1, 20);
    chk("stuck_high_count", vh.size() - vb, 3);
    drive(1'b0, 30);
    vb = vh.size();
    rb = rq.size();
    for (int k = 0; k < 3; k++) drive_period(20, 50);
    drive(1'b1, 1);
    drive(1'b0, 4);
    chk_run("resume", vb, rb, 3, 20, 50);
    do_reset(1);
    vb = vh.size();
    for (int k = 0; k < 2; k++) drive_period(30, 101);
    drive(1'b0, 5);
    chk("period101_count", vh.size() - vb, 0);
    chk("period101_no_signal", int'(no_signal), 1);
    do_reset(1);
    for (int k = 0; k < 3; k++) drive_period(20, 50);
    drive(1'b1, 10);
    chk("pre_reset_high", int'(high_cnt), 20);
    do_reset(1);
    chk_reset_state("mid_high");
    vb = vh.size();
    rb = rq.size();
    drive(1'b0, 20);
    for (int k = 0; k < 3; k++) drive_period(20, 50);
    drive(1'b1, 1);
    drive(1'b0, 4);
    chk_run("after_reset", vb, rb, 3, 20, 50);
    do_reset(2);
    vb = vh.size();
    for (int k = 0; k < 3; k++) drive_period(10, 50);
    for (int k = 0; k < 3; k++) drive_period(30, 50);
    drive(1'b1, 1);
    drive(1'b0, 4);
    chk("duty_change_count", vh.size() - vb, 6);
    for (int i = 0; i < 6 && vb + i < vh.size(); i++) begin
      chk("duty_change_high", vh[vb + i], i < 3 ? 10 : 30);
      chk("duty_change_period", vp[vb + i], 50);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
